tile_turn_sequencer: RTL and testbench



---
 rtl/tile_pkg.sv | 21 ++
 rtl/tile_turn_sequencer_if.sv | 43 ++++
 rtl/tile_onehot_decode.sv | 23 ++
 rtl/tile_turn_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_tile_turn_sequencer.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tile_pkg.sv
// Shared types and constants for the tile-matching turn sequencer.
package tile_pkg;

    localparam int SYM_W_DEF = 4;
    localparam int MOVE_W    = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PICK1   = 3'd1,
        PICK2   = 3'd2,
        REVEAL  = 3'd3,
        RESOLVE = 3'd4,
        DONE    = 3'd5
    } state_e;

    // Index width for n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tile_turn_sequencer_if.sv
// Game-play signals between mode FSM/switches, the sequencer and the display block.
// out_of_moves exists only when TILE_MOVE_LIMIT_EN is defined.
interface tile_turn_sequencer_if
    import tile_pkg::*;
#(
    parameter int NUM_TILES = 10,
    parameter int SYM_W     = SYM_W_DEF
);
    logic                       ingame_on;
    logic                       sel_pulse;
    logic [NUM_TILES-1:0]       sel_onehot;
    logic [NUM_TILES*SYM_W-1:0] tile_symbols;
    logic [NUM_TILES-1:0]       revealed;
    logic [NUM_TILES-1:0]       matched;
    logic [SYM_W-1:0]           first_sym;
    logic [SYM_W-1:0]           second_sym;
    logic [MOVE_W-1:0]          move_count;
    logic                       sel_error;
    logic                       busy;
    logic                       game_over;
`ifdef TILE_MOVE_LIMIT_EN
    logic                       out_of_moves;
`endif

    modport master (
        output ingame_on, sel_pulse, sel_onehot, tile_symbols,
        input  revealed, matched, first_sym, second_sym, move_count,
               sel_error, busy, game_over
`ifdef TILE_MOVE_LIMIT_EN
        , input out_of_moves
`endif
    );

    modport slave (
        input  ingame_on, sel_pulse, sel_onehot, tile_symbols,
        output revealed, matched, first_sym, second_sym, move_count,
               sel_error, busy, game_over
`ifdef TILE_MOVE_LIMIT_EN
        , output out_of_moves
`endif
    );

endinterface

// File: rtl/tile_onehot_decode.sv
// Switch vector to tile index; valid only when exactly one switch is set.
module tile_onehot_decode
    import tile_pkg::*;
#(
    parameter int NUM_TILES = 10,
    parameter int IDX_W     = idx_w(NUM_TILES)
) (
    input  logic [NUM_TILES-1:0] onehot_i,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 valid_o
);

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < NUM_TILES; i++) begin
            if (onehot_i[i]) idx_o = IDX_W'(i);
        end
    end

    // Non-zero with no second bit set.
    assign valid_o = (onehot_i != '0) && ((onehot_i & (onehot_i - 1'b1)) == '0);

endmodule

// File: rtl/tile_turn_sequencer.sv
// One turn of the tile-matching game: two picks, timed reveal, then match or hide.
// Build macro TILE_MOVE_LIMIT_EN ends the game after MAX_MOVES turns and adds out_of_moves.
//   state   | meaning
//   IDLE    | not in play; board, picks and move count cleared
//   PICK1   | waiting for the first tile
//   PICK2   | waiting for the second tile
//   REVEAL  | both picks visible while the timer runs down
//   RESOLVE | mark pair matched or hide it; count the move
//   DONE    | game over; outputs held until ingame_on drops
module tile_turn_sequencer
    import tile_pkg::*;
#(
    parameter int NUM_TILES     = 10,
    parameter int SYM_W         = SYM_W_DEF,
    parameter int REVEAL_CYCLES = 50_000_000
`ifdef TILE_MOVE_LIMIT_EN
    , parameter int MAX_MOVES   = 99
`endif
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    tile_turn_sequencer_if.slave  bus
);

    localparam int IDX_W = idx_w(NUM_TILES);
    localparam int TMR_W = idx_w(REVEAL_CYCLES);
    localparam logic [TMR_W-1:0]     TMR_LOAD    = TMR_W'(REVEAL_CYCLES - 1);
    localparam logic [NUM_TILES-1:0] ALL_MATCHED = '1;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx1_q, idx1_d, idx2_q, idx2_d;
    logic                  held1_q, held1_d, held2_q, held2_d;
    logic [NUM_TILES-1:0]  matched_q, matched_d;
    logic [SYM_W-1:0]      first_sym_q, first_sym_d, second_sym_q, second_sym_d;
    logic [MOVE_W-1:0]     move_count_q, move_count_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic                  sel_error_q, sel_error_d;

    logic [IDX_W-1:0]      sel_idx;
    logic                  sel_valid;
    logic [SYM_W-1:0]      sel_sym;
    logic [NUM_TILES-1:0]  held_mask;
    logic                  sel_ok1, sel_ok2;

    tile_onehot_decode #(
        .NUM_TILES (NUM_TILES),
        .IDX_W     (IDX_W)
    ) u_decode (
        .onehot_i (bus.sel_onehot),
        .idx_o    (sel_idx),
        .valid_o  (sel_valid)
    );

    always_comb begin
        sel_sym = '0;
        for (int i = 0; i < NUM_TILES; i++) begin
            if (bus.sel_onehot[i]) sel_sym = bus.tile_symbols[i*SYM_W +: SYM_W];
        end
    end

    always_comb begin
        held_mask = '0;
        for (int i = 0; i < NUM_TILES; i++) begin
            if (held1_q && idx1_q == IDX_W'(i)) held_mask[i] = 1'b1;
            if (held2_q && idx2_q == IDX_W'(i)) held_mask[i] = 1'b1;
        end
    end

    assign sel_ok1 = sel_valid && ((bus.sel_onehot & matched_q) == '0);
    assign sel_ok2 = sel_ok1 && !(held1_q && sel_idx == idx1_q);

    always_comb begin
        state_d      = state_q;
        idx1_d       = idx1_q;
        idx2_d       = idx2_q;
        held1_d      = held1_q;
        held2_d      = held2_q;
        matched_d    = matched_q;
        first_sym_d  = first_sym_q;
        second_sym_d = second_sym_q;
        move_count_d = move_count_q;
        timer_d      = timer_q;
        sel_error_d  = 1'b0;

        // Leaving play abandons the turn at once, even with a select pending.
        if (!bus.ingame_on || state_q == IDLE) begin
            idx1_d       = '0;
            idx2_d       = '0;
            held1_d      = 1'b0;
            held2_d      = 1'b0;
            matched_d    = '0;
            first_sym_d  = '0;
            second_sym_d = '0;
            move_count_d = '0;
            timer_d      = '0;
            state_d      = bus.ingame_on ? PICK1 : IDLE;
        end else begin
            case (state_q)
                PICK1: begin
                    if (bus.sel_pulse) begin
                        if (sel_ok1) begin
                            idx1_d      = sel_idx;
                            held1_d     = 1'b1;
                            first_sym_d = sel_sym;
                            state_d     = PICK2;
                        end else begin
                            sel_error_d = 1'b1;
                        end
                    end
                end
                PICK2: begin
                    if (bus.sel_pulse) begin
                        if (sel_ok2) begin
                            idx2_d       = sel_idx;
                            held2_d      = 1'b1;
                            second_sym_d = sel_sym;
                            timer_d      = TMR_LOAD;
                            state_d      = REVEAL;
                        end else begin
                            sel_error_d = 1'b1;
                        end
                    end
                end
                REVEAL: begin
                    if (timer_q == '0) state_d = RESOLVE;
                    else               timer_d = timer_q - 1'b1;
                end
                RESOLVE: begin
                    if (first_sym_q == second_sym_q) matched_d = matched_q | held_mask;
                    held1_d      = 1'b0;
                    held2_d      = 1'b0;
                    first_sym_d  = '0;
                    second_sym_d = '0;
                    move_count_d = (move_count_q == '1) ? move_count_q : move_count_q + 1'b1;
                    if (matched_d == ALL_MATCHED) begin
                        state_d = DONE;
`ifdef TILE_MOVE_LIMIT_EN
                    end else if (move_count_d == MOVE_W'(MAX_MOVES)) begin
                        state_d = DONE;
`endif
                    end else begin
                        state_d = PICK1;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q      <= IDLE;
            idx1_q       <= '0;
            idx2_q       <= '0;
            held1_q      <= 1'b0;
            held2_q      <= 1'b0;
            matched_q    <= '0;
            first_sym_q  <= '0;
            second_sym_q <= '0;
            move_count_q <= '0;
            timer_q      <= '0;
            sel_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx1_q       <= idx1_d;
            idx2_q       <= idx2_d;
            held1_q      <= held1_d;
            held2_q      <= held2_d;
            matched_q    <= matched_d;
            first_sym_q  <= first_sym_d;
            second_sym_q <= second_sym_d;
            move_count_q <= move_count_d;
            timer_q      <= timer_d;
            sel_error_q  <= sel_error_d;
        end
    end

    assign bus.revealed   = matched_q | held_mask;
    assign bus.matched    = matched_q;
    assign bus.first_sym  = first_sym_q;
    assign bus.second_sym = second_sym_q;
    assign bus.move_count = move_count_q;
    assign bus.sel_error  = sel_error_q;
    assign bus.busy       = (state_q == REVEAL) || (state_q == RESOLVE);
    assign bus.game_over  = (state_q == DONE);
`ifdef TILE_MOVE_LIMIT_EN
    assign bus.out_of_moves = (state_q == DONE) && (matched_q != ALL_MATCHED);
`endif

endmodule

// File: tb/tb_tile_turn_sequencer.sv
// Directed bench for tile_turn_sequencer with a 10-tile board and a 4-cycle reveal.
module tb_tile_turn_sequencer;
    import tile_pkg::*;

    localparam int N  = 10;
    localparam int SW = 4;
    localparam int RC = 4;
    localparam int SYMS [N] = '{3, 2, 7, 9, 5, 3, 2, 7, 9, 5};

    logic clk = 1'b0;
    logic resetn;
    int   vecs = 0;
    int   errs = 0;

    tile_turn_sequencer_if #(.NUM_TILES(N), .SYM_W(SW)) bus ();

    tile_turn_sequencer #(
        .NUM_TILES     (N),
        .SYM_W         (SW),
        .REVEAL_CYCLES (RC)
`ifdef TILE_MOVE_LIMIT_EN
        , .MAX_MOVES   (3)
`endif
    ) dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pick(input logic [N-1:0] oh);
        bus.sel_pulse  = 1'b1;
        bus.sel_onehot = oh;
        tick();
        bus.sel_pulse  = 1'b0;
        bus.sel_onehot = '0;
    endtask

    task automatic new_game();
        bus.ingame_on = 1'b0;
        tick();
        bus.ingame_on = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bus.ingame_on = 1'b1;
        tick();
        tick();
        vecs++;
        if ({bus.revealed, bus.matched, bus.first_sym, bus.second_sym, bus.move_count,
             bus.sel_error, bus.busy, bus.game_over} !== '0) begin
            errs++;
            $display("FAIL reset_outputs: got rev=%h mat=%h f=%h s=%h mc=%0d err=%b busy=%b go=%b, want all 0",
                     bus.revealed, bus.matched, bus.first_sym, bus.second_sym, bus.move_count,
                     bus.sel_error, bus.busy, bus.game_over);
        end
        vecs++;
        if (dut.state_q !== IDLE) begin
            errs++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q);
        end
        resetn = 1'b1;
    endtask

    task automatic test_match();
        tick();
        vecs++;
        if (dut.state_q !== PICK1) begin errs++; $display("FAIL match_start: state %0d want PICK1", dut.state_q); end
        pick(10'h001);
        vecs++;
        if (dut.state_q !== PICK2 || bus.revealed !== 10'h001 || bus.first_sym !== 4'd3) begin
            errs++; $display("FAIL match_pick1: state %0d rev %h f %h, want PICK2 001 3", dut.state_q, bus.revealed, bus.first_sym);
        end
        pick(10'h020);
        for (int k = 0; k < RC; k++) begin
            vecs++;
            if (dut.state_q !== REVEAL || bus.revealed !== 10'h021 || bus.busy !== 1'b1 || bus.second_sym !== 4'd3) begin
                errs++; $display("FAIL match_reveal[%0d]: state %0d rev %h busy %b s %h, want REVEAL 021 1 3",
                                 k, dut.state_q, bus.revealed, bus.busy, bus.second_sym);
            end
            tick();
        end
        vecs++;
        if (dut.state_q !== RESOLVE) begin errs++; $display("FAIL match_resolve: state %0d want RESOLVE", dut.state_q); end
        tick();
        vecs++;
        if (dut.state_q !== PICK1 || bus.matched !== 10'h021 || bus.revealed !== 10'h021 ||
            bus.move_count !== 8'd1 || bus.first_sym !== 4'd0 || bus.second_sym !== 4'd0 || bus.busy !== 1'b0) begin
            errs++; $display("FAIL match_after: state %0d mat %h rev %h mc %0d f %h s %h busy %b, want PICK1 021 021 1 0 0 0",
                             dut.state_q, bus.matched, bus.revealed, bus.move_count, bus.first_sym, bus.second_sym, bus.busy);
        end
    endtask

    task automatic test_mismatch();
        new_game();
        vecs++;
        if (dut.state_q !== PICK1 || bus.matched !== '0 || bus.move_count !== 8'd0) begin
            errs++; $display("FAIL mismatch_newgame: state %0d mat %h mc %0d, want PICK1 0 0", dut.state_q, bus.matched, bus.move_count);
        end
        pick(10'h002);
        pick(10'h004);
        for (int k = 0; k < RC; k++) begin
            vecs++;
            if (dut.state_q !== REVEAL || bus.revealed !== 10'h006 || bus.first_sym !== 4'd2 || bus.second_sym !== 4'd7) begin
                errs++; $display("FAIL mismatch_reveal[%0d]: state %0d rev %h f %h s %h, want REVEAL 006 2 7",
                                 k, dut.state_q, bus.revealed, bus.first_sym, bus.second_sym);
            end
            tick();
        end
        tick();
        vecs++;
        if (dut.state_q !== PICK1 || bus.revealed !== '0 || bus.matched !== '0 || bus.move_count !== 8'd1 ||
            bus.first_sym !== 4'd0 || bus.second_sym !== 4'd0) begin
            errs++; $display("FAIL mismatch_after: state %0d rev %h mat %h mc %0d f %h s %h, want PICK1 0 0 1 0 0",
                             dut.state_q, bus.revealed, bus.matched, bus.move_count, bus.first_sym, bus.second_sym);
        end
    endtask

    task automatic test_reject();
        pick(10'h003);
        vecs++;
        if (bus.sel_error !== 1'b1 || dut.state_q !== PICK1 || bus.revealed !== '0) begin
            errs++; $display("FAIL rej_twohot: err %b state %0d rev %h, want 1 PICK1 0", bus.sel_error, dut.state_q, bus.revealed);
        end
        tick();
        vecs++;
        if (bus.sel_error !== 1'b0) begin errs++; $display("FAIL rej_pulse_width: err %b want 0", bus.sel_error); end
        pick(10'h000);
        vecs++;
        if (bus.sel_error !== 1'b1 || dut.state_q !== PICK1) begin
            errs++; $display("FAIL rej_none: err %b state %0d, want 1 PICK1", bus.sel_error, dut.state_q);
        end
        pick(10'h001);
        pick(10'h001);
        vecs++;
        if (bus.sel_error !== 1'b1 || dut.state_q !== PICK2 || bus.revealed !== 10'h001 || bus.second_sym !== 4'd0) begin
            errs++; $display("FAIL rej_same_tile: err %b state %0d rev %h s %h, want 1 PICK2 001 0",
                             bus.sel_error, dut.state_q, bus.revealed, bus.second_sym);
        end
        pick(10'h020);
        pick(10'h040);
        vecs++;
        if (bus.sel_error !== 1'b0 || dut.state_q !== REVEAL || bus.revealed !== 10'h021) begin
            errs++; $display("FAIL rej_busy: err %b state %0d rev %h, want 0 REVEAL 021", bus.sel_error, dut.state_q, bus.revealed);
        end
        repeat (4) tick();
        vecs++;
        if (dut.state_q !== PICK1 || bus.matched !== 10'h021 || bus.move_count !== 8'd2) begin
            errs++; $display("FAIL rej_resolved: state %0d mat %h mc %0d, want PICK1 021 2", dut.state_q, bus.matched, bus.move_count);
        end
        pick(10'h020);
        vecs++;
        if (bus.sel_error !== 1'b1 || dut.state_q !== PICK1 || bus.first_sym !== 4'd0) begin
            errs++; $display("FAIL rej_matched_p1: err %b state %0d f %h, want 1 PICK1 0", bus.sel_error, dut.state_q, bus.first_sym);
        end
        pick(10'h002);
        pick(10'h001);
        vecs++;
        if (bus.sel_error !== 1'b1 || dut.state_q !== PICK2 || bus.revealed !== 10'h023) begin
            errs++; $display("FAIL rej_matched_p2: err %b state %0d rev %h, want 1 PICK2 023", bus.sel_error, dut.state_q, bus.revealed);
        end
    endtask

    task automatic test_full_game();
        logic [N-1:0] oh;
        new_game();
        for (int p = 0; p < N/2; p++) begin
            oh = N'(1) << p;
            pick(oh);
            oh = N'(1) << (p + N/2);
            pick(oh);
            repeat (RC + 1) tick();
            vecs++;
            if (dut.state_q !== ((p == N/2 - 1) ? DONE : PICK1) || bus.game_over !== (p == N/2 - 1) ||
                bus.move_count !== 8'(p + 1)) begin
                errs++; $display("FAIL full_pair[%0d]: state %0d go %b mc %0d, want %s %0d",
                                 p, dut.state_q, bus.game_over, bus.move_count, (p == N/2 - 1) ? "DONE" : "PICK1", p + 1);
            end
        end
        vecs++;
        if (bus.matched !== 10'h3FF || bus.revealed !== 10'h3FF || bus.busy !== 1'b0) begin
            errs++; $display("FAIL full_board: mat %h rev %h busy %b, want 3ff 3ff 0", bus.matched, bus.revealed, bus.busy);
        end
        pick(10'h001);
        vecs++;
        if (bus.sel_error !== 1'b0 || dut.state_q !== DONE || bus.game_over !== 1'b1 || bus.move_count !== 8'd5) begin
            errs++; $display("FAIL full_done_hold: err %b state %0d go %b mc %0d, want 0 DONE 1 5",
                             bus.sel_error, dut.state_q, bus.game_over, bus.move_count);
        end
        bus.ingame_on = 1'b0;
        tick();
        vecs++;
        if (dut.state_q !== IDLE || {bus.revealed, bus.matched, bus.move_count, bus.game_over, bus.busy} !== '0) begin
            errs++; $display("FAIL full_exit: state %0d rev %h mat %h mc %0d go %b, want IDLE and zeros",
                             dut.state_q, bus.revealed, bus.matched, bus.move_count, bus.game_over);
        end
        bus.ingame_on = 1'b1;
        tick();
    endtask

`ifdef TILE_MOVE_LIMIT_EN
    task automatic test_move_limit();
        new_game();
        for (int m = 0; m < 3; m++) begin
            pick(10'h001);
            pick(10'h002);
            repeat (RC + 1) tick();
            vecs++;
            if (dut.state_q !== ((m == 2) ? DONE : PICK1) || bus.game_over !== (m == 2) ||
                bus.out_of_moves !== (m == 2) || bus.move_count !== 8'(m + 1)) begin
                errs++; $display("FAIL limit_move[%0d]: state %0d go %b oom %b mc %0d, want mc %0d",
                                 m, dut.state_q, bus.game_over, bus.out_of_moves, bus.move_count, m + 1);
            end
        end
        vecs++;
        if (bus.matched !== '0 || bus.revealed !== '0) begin
            errs++; $display("FAIL limit_board: mat %h rev %h, want 0 0", bus.matched, bus.revealed);
        end
    endtask
`endif

    task automatic test_reset_mid_reveal();
        new_game();
        pick(10'h001);
        pick(10'h020);
        tick();
        vecs++;
        if (dut.state_q !== REVEAL) begin errs++; $display("FAIL rst_mid_setup: state %0d want REVEAL", dut.state_q); end
        resetn = 1'b0;
        tick();
        vecs++;
        if (dut.state_q !== IDLE || {bus.revealed, bus.matched, bus.first_sym, bus.second_sym, bus.move_count,
                                     bus.sel_error, bus.busy, bus.game_over} !== '0) begin
            errs++; $display("FAIL rst_mid_reveal: state %0d rev %h f %h s %h busy %b, want IDLE and zeros",
                             dut.state_q, bus.revealed, bus.first_sym, bus.second_sym, bus.busy);
        end
        resetn = 1'b1;
        tick();
        vecs++;
        if (dut.state_q !== PICK1) begin errs++; $display("FAIL rst_mid_resume: state %0d want PICK1", dut.state_q); end
    endtask

    task automatic test_abandon();
        pick(10'h002);
        vecs++;
        if (dut.state_q !== PICK2 || bus.revealed !== 10'h002) begin
            errs++; $display("FAIL abandon_setup: state %0d rev %h, want PICK2 002", dut.state_q, bus.revealed);
        end
        bus.ingame_on  = 1'b0;
        bus.sel_pulse  = 1'b1;
        bus.sel_onehot = 10'h040;
        tick();
        bus.sel_pulse  = 1'b0;
        bus.sel_onehot = '0;
        vecs++;
        if (dut.state_q !== IDLE || bus.revealed !== '0 || bus.sel_error !== 1'b0 ||
            bus.first_sym !== 4'd0 || bus.second_sym !== 4'd0) begin
            errs++; $display("FAIL abandon: state %0d rev %h err %b f %h s %h, want IDLE 0 0 0 0",
                             dut.state_q, bus.revealed, bus.sel_error, bus.first_sym, bus.second_sym);
        end
        bus.ingame_on = 1'b1;
    endtask

    initial begin
        resetn         = 1'b0;
        bus.ingame_on  = 1'b0;
        bus.sel_pulse  = 1'b0;
        bus.sel_onehot = '0;
        for (int i = 0; i < N; i++) bus.tile_symbols[i*SW +: SW] = SW'(SYMS[i]);
        test_reset();
        test_match();
        test_mismatch();
        test_reject();
`ifdef TILE_MOVE_LIMIT_EN
        test_move_limit();
`else
        test_full_game();
`endif
        test_reset_mid_reveal();
        test_abandon();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

endmodule
